// File: rtl/nios_mul_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with per-operand signedness and hi/lo select.
// Optional overflow flag when NIOS_MUL_OVF_EN is defined.
module nios_mul_pipe #(
    parameter int                DATA_W       = 32,
    parameter int                OUT_REG      = 1,
    parameter logic [DATA_W-1:0] RESET_RESULT = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              sign1,
    input  logic              sign2,
    input  logic              hi_sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] result
`ifdef NIOS_MUL_OVF_EN
    ,
    output logic              ovf
`endif
);
    localparam int N      = DATA_W / 16;
    localparam int NPP    = N * N;
    localparam int PW     = 2 * DATA_W;
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    // Unsigned 16x16 partial products plus the terms that turn them into a signed product.
    typedef struct packed {
        logic [NPP-1:0][31:0] pp;
        logic [DATA_W:0]      corr;
        logic                 hi_sel;
`ifdef NIOS_MUL_OVF_EN
        logic                 sgn;
`endif
    } s1_t;

    logic [NPP-1:0][31:0] pp_d;
    s1_t                  s1_d, s1_q;
    logic [STAGES:1]      vld_pipe;
    logic [PW-1:0]        prod;
    logic [DATA_W-1:0]    sel, res_v;

    genvar gi, gj;
    for (gi = 0; gi < N; gi++) begin : g_a
        for (gj = 0; gj < N; gj++) begin : g_b
            assign pp_d[gi*N+gj] = 32'(src1[16*gi +: 16]) * 32'(src2[16*gj +: 16]);
        end
    end

    // A negative operand contributes -(other operand) << DATA_W on top of the unsigned product.
    always_comb begin
        s1_d        = '0;
        s1_d.pp     = pp_d;
        s1_d.corr   = ((sign1 & src1[DATA_W-1]) ? {1'b0, src2} : '0)
                    + ((sign2 & src2[DATA_W-1]) ? {1'b0, src1} : '0);
        s1_d.hi_sel = hi_sel;
`ifdef NIOS_MUL_OVF_EN
        s1_d.sgn    = sign1 | sign2;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  s1_q <= '0;
        else if (en)   s1_q <= s1_d;
    end

    // Flush wins over en: it clears valids even during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod = prod + (PW'(s1_q.pp[i*N+j]) << (16*(i+j)));
        prod = prod - (PW'(s1_q.corr) << DATA_W);
    end

    assign sel = s1_q.hi_sel ? prod[PW-1:DATA_W] : prod[DATA_W-1:0];

`ifdef NIOS_MUL_OVF_EN
    logic            ovf_c, ovf_v;
    logic [DATA_W:0] top;
    assign top   = prod[PW-1:DATA_W-1];
    assign ovf_c = ~s1_q.hi_sel & (s1_q.sgn ? ~((&top) | ~(|top)) : (|prod[PW-1:DATA_W]));
`endif

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] res_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) res_q <= RESET_RESULT;
            else if (en)  res_q <= sel;
        end
        assign res_v = res_q;
`ifdef NIOS_MUL_OVF_EN
        logic ovf_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) ovf_q <= 1'b0;
            else if (en)  ovf_q <= ovf_c;
        end
        assign ovf_v = ovf_q;
`endif
    end else begin : g_comb
        assign res_v = sel;
`ifdef NIOS_MUL_OVF_EN
        assign ovf_v = ovf_c;
`endif
    end

    assign out_valid = vld_pipe[STAGES];
    assign result    = out_valid ? res_v : RESET_RESULT;
`ifdef NIOS_MUL_OVF_EN
    assign ovf       = out_valid & ovf_v;
`endif

endmodule

// File: tb/tb_nios_mul_pipe.sv
// Scoreboard bench for nios_mul_pipe: 32-bit registered-output instance plus a 16-bit
// combinational-output instance for the short-latency case.
module tb_nios_mul_pipe;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        en, flush, in_valid, sign1, sign2, hi_sel;
    logic [31:0] src1, src2;
    logic        out_valid;
    logic [31:0] result;
    logic        en16, flush16, iv16, s1_16, s2_16, hi16;
    logic [15:0] a16, b16;
    logic        ov16;
    logic [15:0] res16;
`ifdef NIOS_MUL_OVF_EN
    logic        ovf, ovf16;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nios_mul_pipe #(.DATA_W(32), .OUT_REG(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
        .src1(src1), .src2(src2), .sign1(sign1), .sign2(sign2), .hi_sel(hi_sel),
        .out_valid(out_valid), .result(result)
`ifdef NIOS_MUL_OVF_EN
        , .ovf(ovf)
`endif
    );

    nios_mul_pipe #(.DATA_W(16), .OUT_REG(0)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .en(en16), .flush(flush16), .in_valid(iv16),
        .src1(a16), .src2(b16), .sign1(s1_16), .sign2(s2_16), .hi_sel(hi16),
        .out_valid(ov16), .result(res16)
`ifdef NIOS_MUL_OVF_EN
        , .ovf(ovf16)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b,
                                     input logic s1, input logic s2, input logic hi);
        logic signed [32:0] xa, xb;
        logic signed [65:0] p;
        exp_t e;
        xa = {s1 & a[31], a};
        xb = {s2 & b[31], b};
        p  = xa * xb;
        e.res = hi ? p[63:32] : p[31:0];
        if (hi)            e.ovf = 1'b0;
        else if (s1 | s2)  e.ovf = (p > 66'sh7FFFFFFF) || (p < -66'sh80000000);
        else               e.ovf = (p > 66'sh0FFFFFFFF);
        return e;
    endfunction

    // One clock: check the visible output, update the scoreboard for the coming edge, advance.
    task automatic tick();
        @(negedge clk);
        if (out_valid) begin
            if (sbq.size() == 0) chk("spurious_valid", out_valid, 1'b0);
            else begin
                chk("result", result, sbq[0].res);
`ifdef NIOS_MUL_OVF_EN
                chk("ovf", ovf, sbq[0].ovf);
`endif
            end
        end else begin
            chk("idle_result", result, 32'h0);
`ifdef NIOS_MUL_OVF_EN
            chk("idle_ovf", ovf, 1'b0);
`endif
        end
        if (out_valid && (en || flush) && sbq.size() > 0) void'(sbq.pop_front());
        if (flush)                sbq.delete();
        else if (en && in_valid)  sbq.push_back(ref_mul(src1, src2, sign1, sign2, hi_sel));
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic s1, input logic s2, input logic hi);
        src1 = a; src2 = b; sign1 = s1; sign2 = s2; hi_sel = hi;
        in_valid = 1'b1; en = 1'b1; flush = 1'b0;
    endtask

    task automatic idle();
        src1 = $urandom; src2 = $urandom; sign1 = 1'b0; sign2 = 1'b0; hi_sel = 1'b0;
        in_valid = 1'b0; en = 1'b1; flush = 1'b0;
    endtask

    task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s1, input logic s2, input logic [31:0] exp);
        op(a, b, s1, s2, 1'b1);
        tick();
        idle();
        tick();
        chk({tag, "_v"}, out_valid, 1'b1);
        chk(tag, result, exp);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int issued = 0;
        int cyc = 0;
        reset_n = 1'b0;
        op($urandom, $urandom, 1'b1, 1'b0, 1'b1);
        en16 = 1'b1; flush16 = 1'b0; iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678;
        s1_16 = 1'b0; s2_16 = 1'b0; hi16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_valid16", ov16, 1'b0);
        chk("rst_result16", res16, 16'h0);
        idle();
        iv16 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            tick();
            chk("post_rst_valid", out_valid, 1'b0);
        end

        // unsigned max*max, lo then hi back-to-back
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick();
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        tick();
        chk("uns_lo_v", out_valid, 1'b1);
        chk("uns_lo", result, 32'h0000_0001);
        idle();
        tick();
        chk("uns_hi_v", out_valid, 1'b1);
        chk("uns_hi", result, 32'hFFFF_FFFE);
        tick();
        chk("uns_done_v", out_valid, 1'b0);

        one("mix_su", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF);
        one("mix_ss", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000);
        one("minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000);
        tick();

        // stall: output holds 4, stage-1 holds 15, ops offered during the stall are ignored
        op(32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        tick();
        op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall_pre", result, 32'd4);
        op(32'd11, 32'd11, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_v", out_valid, 1'b1);
            chk("stall_res", result, 32'd4);
        end
        idle();
        tick();
        chk("stall_post_v", out_valid, 1'b1);
        chk("stall_post", result, 32'd15);
        tick();
        chk("stall_end_v", out_valid, 1'b0);

        // flush kills in-flight op and the op presented with it
        op(32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
        tick();
        op(32'd6, 32'd6, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        chk("flush_v0", out_valid, 1'b0);
        idle();
        repeat (2) begin
            tick();
            chk("flush_v", out_valid, 1'b0);
        end

        // flush during a stall still clears valids
        op(32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        en = 1'b0;
        flush = 1'b1;
        tick();
        idle();
        repeat (2) begin
            tick();
            chk("flush_stall_v", out_valid, 1'b0);
        end

        // reset mid-operation
        op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        tick();
        op(32'd6, 32'd6, 1'b0, 1'b0, 1'b0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_v", out_valid, 1'b0);
        chk("midrst_res", result, 32'h0);
        sbq.delete();
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            chk("midrst_post_v", out_valid, 1'b0);
        end

        // 16-bit, combinational output, 1-cycle latency
        a16 = 16'h8000; b16 = 16'h0002; s1_16 = 1'b1; s2_16 = 1'b1; hi16 = 1'b1; iv16 = 1'b1;
        @(posedge clk);
        #1;
        chk("d16_hi_v", ov16, 1'b1);
        chk("d16_hi", res16, 16'hFFFF);
`ifdef NIOS_MUL_OVF_EN
        chk("d16_hi_ovf", ovf16, 1'b0);
`endif
        hi16 = 1'b0;
        @(posedge clk);
        #1;
        chk("d16_lo_v", ov16, 1'b1);
        chk("d16_lo", res16, 16'h0000);
`ifdef NIOS_MUL_OVF_EN
        chk("d16_lo_ovf", ovf16, 1'b1);
`endif
        iv16 = 1'b0;
        a16 = 16'h00FF;
        @(posedge clk);
        #1;
        chk("d16_idle_v", ov16, 1'b0);
        chk("d16_idle", res16, 16'h0000);

        // randomised traffic
        while (issued < 10000 && cyc < 40000) begin
            src1     = rnd32();
            src2     = rnd32();
            sign1    = 1'($urandom);
            sign2    = 1'($urandom);
            hi_sel   = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            en       = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if (en && in_valid && !flush) issued++;
            tick();
            cyc++;
        end
        chk("rand_issued", 64'(issued), 64'd10000);
        idle();
        repeat (4) tick();
        chk("drain", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
